bus_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter_rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
// Optional feature macro: BUS_ARB_LOCK_EN (adds the LOCK input to the bus interface).
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    // Width of a binary index able to address n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // GNT_ID width for the default four-master configuration.
    localparam int ARB_ID_W_DEFAULT = id_width(4);

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// Optional feature macro: BUS_ARB_LOCK_EN (adds the lock signal).
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
`ifdef BUS_ARB_LOCK_EN
    logic               lock;
`endif

    // Requester side: raises requests, watches its grant bit.
    modport master (
        output req,
`ifdef BUS_ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  gnt_id,
        input  busy
    );

    // Arbiter side: reads requests, drives the one-hot grant.
    modport slave (
        input  req,
`ifdef BUS_ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output gnt_id,
        output busy
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        int              j;
        logic [ID_W-1:0] jj;
        win   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j  = (int'(ptr) + i) % NUM_REQ;
            jj = ID_W'(j);
            if (!valid && req[jj]) begin
                valid   = 1'b1;
                win[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tri-state bus arbiter with hold cap and owner-change turnaround.
// Optional feature macro: BUS_ARB_LOCK_EN (lock lets the owner ignore the hold cap).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_HOLD    = 4,
    parameter int TURN_CYCLES = 1
)(
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);

    localparam int ID_W   = id_width(NUM_REQ);
    localparam int HOLD_W = id_width(MAX_HOLD + 1);
    localparam int TURN_W = id_width(TURN_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_GRANT = GRANT;
    localparam logic [1:0] ST_TURN  = TURNAROUND;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic [ID_W-1:0]    ptr;
    logic [HOLD_W-1:0]  hold;
    logic [TURN_W-1:0]  turn;

    logic [NUM_REQ-1:0] pick_win;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_valid;

    logic               owner_req;
    logic               others_pending;
    logic               at_limit;
    logic               locked;
    logic               keep;
    logic [ID_W-1:0]    next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .win   (pick_win),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Decide whether the current owner may keep the bus for another cycle.
    always_comb begin
        owner_req      = bus.req[gnt_id];
        others_pending = |(bus.req & ~gnt);
        at_limit       = (hold >= HOLD_W'(MAX_HOLD));
`ifdef BUS_ARB_LOCK_EN
        locked         = bus.lock;
`else
        locked         = 1'b0;
`endif
        keep           = owner_req && (!at_limit || !others_pending || locked);
        next_ptr       = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    // FSM, counters and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= '0;
            hold   <= '0;
            turn   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt    <= pick_win;
                        gnt_id <= pick_idx;
                        busy   <= 1'b1;
                        hold   <= HOLD_W'(1);
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (keep) begin
                        if (!at_limit) begin
                            hold <= hold + 1'b1;
                        end
                    end else begin
                        // Release: bus goes idle and the pointer moves past the old owner.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                        hold  <= '0;
                        turn  <= TURN_W'(TURN_CYCLES);
                        state <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (turn <= TURN_W'(1)) begin
                        // Last dead cycle: hand over directly, skipping IDLE.
                        turn <= '0;
                        if (pick_valid) begin
                            gnt    <= pick_win;
                            gnt_id <= pick_idx;
                            busy   <= 1'b1;
                            hold   <= HOLD_W'(1);
                            state  <= ST_GRANT;
                        end else begin
                            state  <= ST_IDLE;
                        end
                    end else begin
                        turn <= turn - 1'b1;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt;
    assign bus.gnt_id = gnt_id;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (NUM_REQ=4, MAX_HOLD=4, TURN_CYCLES=1).
// Optional feature macro: BUS_ARB_LOCK_EN enables the lock scenario.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bus_arbiter_if #(.NUM_REQ(4)) bus ();

    bus_arbiter #(
        .NUM_REQ     (4),
        .MAX_HOLD    (4),
        .TURN_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
`ifdef BUS_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = 4'b0000;
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id got=%0d exp=0", bus.gnt_id); end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL idle_no_req got=%b exp=0000", bus.gnt); end
    endtask

    task automatic test_single_grant();
        do_reset();
        bus.req = 4'b0001;
        step();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_first got gnt=%b id=%0d busy=%b exp gnt=0001 id=0 busy=1", bus.gnt, bus.gnt_id, bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_hold cyc=%0d got=%b exp=0001", i, bus.gnt); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [21];
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) exp_seq[k*5 + c] = 4'b0001 << k;
            exp_seq[k*5 + 4] = 4'b0000;
        end
        exp_seq[20] = 4'b0001;
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 21; i++) begin
            step();
            checks++;
            if (bus.gnt !== exp_seq[i]) begin failures++; $display("FAIL rr_seq cyc=%0d got=%b exp=%b", i, bus.gnt, exp_seq[i]); end
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
                failures++;
                $display("FAIL sole_hold cyc=%0d got gnt=%b id=%0d exp gnt=0100 id=2", i, bus.gnt, bus.gnt_id);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        bus.req = 4'b1010;
        step();
        checks++;
        if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL early_own got=%b exp=0010", bus.gnt); end
        step();
        bus.req = 4'b1000;
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL early_turn got gnt=%b busy=%b exp gnt=0000 busy=0", bus.gnt, bus.busy);
        end
        step();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3) begin
            failures++;
            $display("FAIL early_next got gnt=%b id=%0d exp gnt=1000 id=3", bus.gnt, bus.gnt_id);
        end
    endtask

    task automatic test_turn_to_idle();
        do_reset();
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        step();
        step();
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL idle_after_turn got=%b exp=0000", bus.gnt); end
        bus.req = 4'b0101;
        step();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
            failures++;
            $display("FAIL idle_ptr_moved got gnt=%b id=%0d exp gnt=0100 id=2", bus.gnt, bus.gnt_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0100;
        step();
        step();
        checks++;
        if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL areset_pre got=%b exp=0100", bus.gnt); end
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_now got gnt=%b busy=%b exp gnt=0000 busy=0", bus.gnt, bus.busy);
        end
        bus.req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL areset_ptr got=%b exp=0001", bus.gnt); end
    endtask

`ifdef BUS_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        bus.lock = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL lock_hold cyc=%0d got=%b exp=0001", i, bus.gnt); end
        end
        bus.lock = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL lock_release got=%b exp=0000", bus.gnt); end
        step();
        checks++;
        if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL lock_next got=%b exp=0010", bus.gnt); end
    endtask
`endif

    initial begin
        bus.req = 4'b0000;
`ifdef BUS_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_single_grant();
        test_round_robin();
        test_sole_requester();
        test_early_release();
        test_turn_to_idle();
        test_async_reset();
`ifdef BUS_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
